bcd_to_bin_serial: RTL and testbench
====================================

Name: bcd_to_bin_serial

Overview:
- Sequential 3-digit BCD to 9-bit binary converter. It is the inverse of the existing combinational binary-to-BCD block.
- Uses reverse double-dabble: one shift/correct step per clock, 9 steps per conversion.
- Sits between BCD keypad/display-side logic and binary datapath logic. Uses a valid/ready input handshake and a one-cycle out_valid pulse.

Parameters:
- OUT_HOLD, 1, 1: out_bin holds the last result until the next result. 0: out_bin is driven to 0 whenever out_valid is low.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- in_valid  input  1  BCD operand valid
- in_hundred  input  3  hundreds digit, 0-7
- in_ten  input  4  tens digit
- in_unit  input  4  units digit
- in_ready  output  1  high when the block can accept an operand
- out_valid  output  1  one-cycle pulse, result valid
- out_bin  output  9  binary result
- out_err  output  1  range/format error, valid with out_valid

Behaviour:
- Reset: synchronous to clk, active-high.
  - On the rst edge: state=IDLE, in_ready=1, out_valid=0, out_bin=0, out_err=0, step counter=0.
  - rst takes priority over all other inputs and aborts any conversion in flight. No out_valid is produced for an aborted operand.
- States:
  - IDLE: in_ready=1.
  - CONV: in_ready=0.
  - No separate DONE state.
- IDLE to CONV: on an edge where in_valid&&in_ready, capture the shift register {4'(in_hundred), in_ten, in_unit, 9'b0} (21 bits) and set cnt=0.
- Each CONV edge performs one step:
  - Shift the 21-bit register right by 1; the units LSB enters the MSB of the binary field.
  - Then, for each of the 3 digit nibbles, if the nibble is 8 or more, subtract 3.
  - cnt increments.
- Completion: on the CONV edge where cnt==8 (the 9th step):
  - state returns to IDLE;
  - out_valid=1 for exactly one cycle;
  - out_bin = the binary field after that step;
  - out_err is loaded.
- Latency: operand accepted at edge k; out_valid is high in the cycle following edge k+9. in_ready is high again in that same cycle, so a back-to-back operand can be accepted at edge k+10.
- Throughput: one conversion per 10 cycles.
- in_valid while in_ready=0 is ignored: no capture, no queueing, operands are not modified.
- Digit inputs are sampled only at the capture edge; changes during CONV have no effect.
- OUT_HOLD=1: out_bin and out_err hold after the pulse until the next completion.
- OUT_HOLD=0: out_bin and out_err are 0 whenever out_valid=0.
- All outputs are registered; there is no combinational path from inputs to outputs.

Optional Feature:
- Macro: BCD_RANGE_CHECK_EN.
- Defined: at capture, flag an error if either of these holds:
  - any of in_ten or in_unit is greater than 9;
  - the decimal value 100*H+10*T+U is greater than 511.
  - The flag is registered alongside the operand and appears on out_err with out_valid. When out_err=1, out_bin is forced to 0. Latency is unchanged.
- Undefined: out_err is tied to 0. Results for illegal inputs are unspecified, but the block must never hang, and completion still occurs after 9 steps.

Decomposition:
- Package bcd_pkg:
  - constants BCD_DIGIT_W=4, BIN_W=9, N_STEPS=9, MAX_DEC=511;
  - typedef enum logic {IDLE, CONV} bcd_state_e;
  - typedef for the 21-bit shift register.
- Sub-module bcd_digit_adj: combinational 4-bit "if nibble is 8 or more, subtract 3". Instantiate it 3 times inside the step logic.

Test Plan:
- Reset release, then H=2 T=5 U=5 in_valid one cycle -> out_valid pulse 10 cycles after capture edge, out_bin=255, out_err=0, in_ready low for 9 cycles.
- Edge values 0/0/0 and 5/1/1 -> out_bin=0 then 511. Back-to-back in_valid held high -> captures exactly every 10 cycles.
- in_valid pulsed with 3/2/1 during CONV of 1/2/3 -> only 123 produced, 321 dropped, no extra out_valid.
- BCD_RANGE_CHECK_EN defined:
  - 5/1/2 -> out_err=1, out_bin=0;
  - 0/10/0 -> out_err=1;
  - 4/9/9 -> out_bin=499, out_err=0.
- rst asserted at step 4 of 3/0/0 -> next edge all outputs 0, in_ready=1, no out_valid. A new operand 0/4/2 gives out_bin=42.
- OUT_HOLD=0 vs 1: after result 100, check out_bin is 0 the cycle after the pulse (OUT_HOLD=0) and stays 100 (OUT_HOLD=1).

Source files
------------

// File: rtl/bcd_to_bin_serial_pkg.sv
// Shared constants and types for the serial BCD-to-binary converter.
// Shift register layout: {hundreds, tens, units, binary result}.
package bcd_pkg;

  localparam int BCD_DIGIT_W = 4;
  localparam int BIN_W       = 9;
  localparam int N_STEPS     = 9;
  localparam int MAX_DEC     = 511;

  typedef enum logic {IDLE, CONV} bcd_state_e;

  typedef struct packed {
    logic [BCD_DIGIT_W-1:0] hun;
    logic [BCD_DIGIT_W-1:0] ten;
    logic [BCD_DIGIT_W-1:0] unit;
    logic [BIN_W-1:0]       bin;
  } bcd_sr_t;

endpackage

// File: rtl/bcd_to_bin_serial_if.sv
// Operand/result bundle: valid/ready BCD input, one-cycle result pulse out.
// slave is the converter side, master is the producer/consumer side.
interface bcd_to_bin_serial_if;
  import bcd_pkg::*;

  logic                   in_valid;
  logic [2:0]             in_hundred;
  logic [BCD_DIGIT_W-1:0] in_ten;
  logic [BCD_DIGIT_W-1:0] in_unit;
  logic                   in_ready;
  logic                   out_valid;
  logic [BIN_W-1:0]       out_bin;
  logic                   out_err;

  modport slave (
    input  in_valid, in_hundred, in_ten, in_unit,
    output in_ready, out_valid, out_bin, out_err
  );

  modport master (
    output in_valid, in_hundred, in_ten, in_unit,
    input  in_ready, out_valid, out_bin, out_err
  );

endinterface

// File: rtl/bcd_to_bin_serial_digit_adj.sv
// One reverse double-dabble correction: nibble >= 8 gets 3 subtracted.
// Purely combinational, no handshake.
module bcd_digit_adj
  import bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] nib_in,
  output logic [BCD_DIGIT_W-1:0] nib_out
);

  assign nib_out = (nib_in >= 4'd8) ? (nib_in - 4'd3) : nib_in;

endmodule

// File: rtl/bcd_to_bin_serial.sv
// 3-digit BCD to 9-bit binary, one shift/correct step per clock; result pulse 10 cycles after capture.
// in_ready is low for the 9 conversion cycles; in_valid during that time is dropped. Optional: BCD_RANGE_CHECK_EN.
module bcd_to_bin_serial
  import bcd_pkg::*;
#(
  parameter bit OUT_HOLD = 1'b1
) (
  input logic                 clk,
  input logic                 rst,
  bcd_to_bin_serial_if.slave  bus
);

  localparam int CNT_W = 4;

  bcd_state_e       state_q, state_d;
  bcd_sr_t          sr_q, sr_d, shifted, step_sr, capture_sr;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             done;
  logic             range_err;
  logic             in_ready_q;
  logic             out_valid_q;
  logic [BIN_W-1:0] out_bin_q;
  logic             out_err_q;

`ifdef BCD_RANGE_CHECK_EN
  logic [9:0] dec_val;
  assign dec_val   = 10'(bus.in_hundred) * 10'd100 + 10'(bus.in_ten) * 10'd10 + 10'(bus.in_unit);
  assign range_err = (bus.in_ten > 4'd9) || (bus.in_unit > 4'd9) || (dec_val > 10'(MAX_DEC));
`else
  assign range_err = 1'b0;
`endif

  assign capture_sr = '{hun: 4'(bus.in_hundred), ten: bus.in_ten, unit: bus.in_unit, bin: '0};

  // Units LSB drops into the MSB of the binary field; then each digit is corrected.
  assign shifted = bcd_sr_t'({1'b0, sr_q[$bits(bcd_sr_t)-1:1]});

  bcd_digit_adj u_adj_hun  (.nib_in(shifted.hun),  .nib_out(step_sr.hun));
  bcd_digit_adj u_adj_ten  (.nib_in(shifted.ten),  .nib_out(step_sr.ten));
  bcd_digit_adj u_adj_unit (.nib_in(shifted.unit), .nib_out(step_sr.unit));
  assign step_sr.bin = shifted.bin;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          state_d = CONV;
          sr_d    = capture_sr;
          cnt_d   = '0;
          err_d   = range_err;
        end
      end
      CONV: begin
        sr_d  = step_sr;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(N_STEPS - 1)) begin
          state_d = IDLE;
          done    = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q        <= '0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_bin_q   <= '0;
      out_err_q   <= 1'b0;
    end else begin
      sr_q        <= sr_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      in_ready_q  <= (state_d == IDLE);
      out_valid_q <= done;
      if (done) begin
        out_err_q <= err_q;
        out_bin_q <= err_q ? '0 : step_sr.bin;
      end else if (!OUT_HOLD) begin
        out_err_q <= 1'b0;
        out_bin_q <= '0;
      end
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_bin   = out_bin_q;
  assign bus.out_err   = out_err_q;

endmodule

// File: tb/tb_bcd_to_bin_serial.sv
// Directed bench: two converters (OUT_HOLD=1 and OUT_HOLD=0) share one stimulus stream.
module tb_bcd_to_bin_serial;
  import bcd_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bcd_to_bin_serial_if bus ();
  bcd_to_bin_serial_if bus0 ();

  assign bus0.in_valid   = bus.in_valid;
  assign bus0.in_hundred = bus.in_hundred;
  assign bus0.in_ten     = bus.in_ten;
  assign bus0.in_unit    = bus.in_unit;

  bcd_to_bin_serial #(.OUT_HOLD(1'b1)) dut  (.clk(clk), .rst(rst), .bus(bus));
  bcd_to_bin_serial #(.OUT_HOLD(1'b0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));

  int checks   = 0;
  int failures = 0;
  int lows;
  int spur;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic count_cycle();
    if (!bus.in_ready) lows++;
    if (bus.out_valid) spur++;
  endtask

  task automatic start(input int h, input int t, input int u);
    bus.in_hundred = 3'(h);
    bus.in_ten     = 4'(t);
    bus.in_unit    = 4'(u);
    bus.in_valid   = 1'b1;
    tick();
    bus.in_valid   = 1'b0;
    lows = 0;
    spur = 0;
    count_cycle();
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      count_cycle();
    end
  endtask

  task automatic finish_chk(input string tag, input int exp_bin, input int exp_err);
    tick();
    check({tag, "_valid"}, int'(bus.out_valid), 1);
    check({tag, "_bin"},   int'(bus.out_bin),   exp_bin);
    check({tag, "_err"},   int'(bus.out_err),   exp_err);
    check({tag, "_ready"}, int'(bus.in_ready),  1);
    check({tag, "_lows"},  lows, 9);
    check({tag, "_spur"},  spur, 0);
  endtask

  task automatic convert(input string tag, input int h, input int t, input int u,
                         input int exp_bin, input int exp_err);
    start(h, t, u);
    wait_cycles(8);
    finish_chk(tag, exp_bin, exp_err);
  endtask

  initial begin
    int pulses;
    int first_p;
    int last_p;

    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_hundred = '0;
    bus.in_ten = '0;
    bus.in_unit = '0;
    tick();
    tick();
    check("rst_ready", int'(bus.in_ready), 1);
    check("rst_valid", int'(bus.out_valid), 0);
    check("rst_bin", int'(bus.out_bin), 0);
    check("rst_err", int'(bus.out_err), 0);
    rst = 1'b0;
    tick();

    convert("c255", 2, 5, 5, 255, 0);
    convert("c000", 0, 0, 0, 0, 0);
    convert("c511", 5, 1, 1, 511, 0);

    // in_valid held high: captures at edges 0, 10, 20
    bus.in_hundred = 3'd1;
    bus.in_ten = 4'd2;
    bus.in_unit = 4'd8;
    bus.in_valid = 1'b1;
    pulses = 0;
    first_p = -1;
    last_p = -1;
    for (int j = 0; j < 30; j++) begin
      tick();
      if (bus.out_valid) begin
        pulses++;
        if (first_p < 0) first_p = j;
        last_p = j;
        check("b2b_bin", int'(bus.out_bin), 128);
      end
    end
    bus.in_valid = 1'b0;
    check("b2b_pulses", pulses, 3);
    check("b2b_first", first_p, 9);
    check("b2b_last", last_p, 29);

    // Operand offered during CONV must be dropped
    tick();
    start(1, 2, 3);
    wait_cycles(3);
    bus.in_hundred = 3'd3;
    bus.in_ten = 4'd2;
    bus.in_unit = 4'd1;
    bus.in_valid = 1'b1;
    wait_cycles(1);
    bus.in_valid = 1'b0;
    wait_cycles(4);
    finish_chk("drop", 123, 0);
    spur = 0;
    for (int j = 0; j < 12; j++) begin
      tick();
      if (bus.out_valid) spur++;
    end
    check("drop_extra", spur, 0);
    check("drop_hold", int'(bus.out_bin), 123);

    // Reset aborts a conversion in flight
    start(3, 0, 0);
    wait_cycles(3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_valid", int'(bus.out_valid), 0);
    check("abort_bin", int'(bus.out_bin), 0);
    check("abort_err", int'(bus.out_err), 0);
    check("abort_ready", int'(bus.in_ready), 1);
    spur = 0;
    for (int j = 0; j < 12; j++) begin
      tick();
      if (bus.out_valid) spur++;
    end
    check("abort_nopulse", spur, 0);
    convert("c042", 0, 4, 2, 42, 0);

    // OUT_HOLD behaviour after result 100
    convert("c100", 1, 0, 0, 100, 0);
    check("hold0_pulse_bin", int'(bus0.out_bin), 100);
    tick();
    check("hold1_valid", int'(bus.out_valid), 0);
    check("hold1_bin", int'(bus.out_bin), 100);
    check("hold0_bin", int'(bus0.out_bin), 0);
    check("hold0_err", int'(bus0.out_err), 0);

    convert("c499", 4, 9, 9, 499, 0);

`ifdef BCD_RANGE_CHECK_EN
    convert("rng512", 5, 1, 2, 0, 1);
    convert("rng_t10", 0, 10, 0, 0, 1);
    convert("rng_ok", 4, 9, 9, 499, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
